// File: rtl/rv32i_ctrl_fsm_if.sv
// Memory handshake bundle between the RV32I control sequencer and the
// shared instruction/data memory port.
//   mem_req      : request valid, held until mem_ready
//   mem_we       : request is a write (STORE)
//   mem_addr_sel : address source, 0 = PC, 1 = ALU result
//   mem_ready    : memory acknowledge for the current request
interface rv32i_ctrl_fsm_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/rv32i_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I core.
// Walks each instruction through FETCH / DECODE / EXECUTE / MEM / WB over one
// shared memory port, drives the datapath enables and mux selects, counts
// retired instructions and halts on SYSTEM, illegal opcode or memory timeout.
// Ports:
//   clk, reset     : clock (rising edge), asynchronous active-low reset
//   run            : start/continue fetching, looked at on instruction boundaries
//   opcode         : instr[6:0] from the IR, used in DECODE
//   branch_taken   : ALU compare result, used in EXECUTE of a branch
//   mem            : memory handshake (master side)
//   state          : current sequencer state
//   ir_we, reg_we, pc_we : one-cycle write strobes
//   pc_src, alu_a_sel, alu_b_sel, alu_mode, wb_sel : datapath selects
//   halted, halt_cause   : halt indication and reason
//   instret        : retired-instruction counter
module rv32i_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic [6:0]              opcode,
    input  logic                    branch_taken,
    rv32i_ctrl_fsm_if.master        mem,
    output logic [2:0]              state,
    output logic                    ir_we,
    output logic                    reg_we,
    output logic                    pc_we,
    output logic [1:0]              pc_src,
    output logic [1:0]              alu_a_sel,
    output logic                    alu_b_sel,
    output logic [1:0]              alu_mode,
    output logic [1:0]              wb_sel,
    output logic                    halted,
    output logic [1:0]              halt_cause,
    output logic [31:0]             instret
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CL_OP      = 4'd0,
        CL_OPIMM   = 4'd1,
        CL_LUI     = 4'd2,
        CL_AUIPC   = 4'd3,
        CL_LOAD    = 4'd4,
        CL_STORE   = 4'd5,
        CL_BRANCH  = 4'd6,
        CL_JAL     = 4'd7,
        CL_JALR    = 4'd8,
        CL_FENCE   = 4'd9,
        CL_SYSTEM  = 4'd10,
        CL_ILLEGAL = 4'd11
    } class_t;

    // Watchdog counter only needs to reach MEM_TIMEOUT-1.
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WD_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;
    localparam bit WD_EN = (MEM_TIMEOUT != 0);

    // Maps a RV32I major opcode onto the instruction class the sequencer tracks.
    function automatic class_t decode_class(input logic [6:0] op);
        class_t cls;
        case (op)
            7'b0110011: cls = CL_OP;
            7'b0010011: cls = CL_OPIMM;
            7'b0110111: cls = CL_LUI;
            7'b0010111: cls = CL_AUIPC;
            7'b0000011: cls = CL_LOAD;
            7'b0100011: cls = CL_STORE;
            7'b1100011: cls = CL_BRANCH;
            7'b1101111: cls = CL_JAL;
            7'b1100111: cls = CL_JALR;
            7'b0001111: cls = CL_FENCE;
            7'b1110011: cls = CL_SYSTEM;
            default:    cls = CL_ILLEGAL;
        endcase
        return cls;
    endfunction

    state_t         state_r;
    state_t         state_nxt_s;
    class_t         class_r;
    class_t         op_class_s;
    logic [CW-1:0]  wd_cnt_r;
    logic [1:0]     halt_cause_r;
    logic [31:0]    instret_r;

    logic           retire_s;
    logic           halt_set_s;
    logic [1:0]     halt_cause_nxt_s;
    logic           wd_clr_s;
    logic           wd_inc_s;
    logic           timeout_s;

    assign op_class_s = decode_class(opcode);

    // Next-state decode plus every datapath strobe and select.
    always_comb begin
        state_nxt_s       = state_r;
        retire_s          = 1'b0;
        halt_set_s        = 1'b0;
        halt_cause_nxt_s  = 2'd0;
        mem.mem_req       = 1'b0;
        mem.mem_we        = 1'b0;
        mem.mem_addr_sel  = 1'b0;
        ir_we             = 1'b0;
        reg_we            = 1'b0;
        pc_we             = 1'b0;
        pc_src            = 2'd0;
        alu_a_sel         = 2'd0;
        alu_b_sel         = 1'b0;
        alu_mode          = 2'd0;
        wb_sel            = 2'd0;
        wd_inc_s          = 1'b0;
        timeout_s         = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                mem.mem_req = 1'b1;
                wd_inc_s    = !mem.mem_ready;
                timeout_s   = WD_EN && !mem.mem_ready && (wd_cnt_r == WD_LAST);
                if (mem.mem_ready) begin
                    ir_we       = 1'b1;
                    state_nxt_s = ST_DECODE;
                end else if (timeout_s) begin
                    state_nxt_s      = ST_HALT;
                    halt_set_s       = 1'b1;
                    halt_cause_nxt_s = 2'd3;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (op_class_s)
                    CL_FENCE: begin
                        retire_s = 1'b1;
                    end
                    CL_SYSTEM: begin
                        state_nxt_s      = ST_HALT;
                        halt_set_s       = 1'b1;
                        halt_cause_nxt_s = 2'd1;
                    end
                    CL_ILLEGAL: begin
                        state_nxt_s      = ST_HALT;
                        halt_set_s       = 1'b1;
                        halt_cause_nxt_s = 2'd2;
                    end
                    default: begin
                        state_nxt_s = ST_EXECUTE;
                    end
                endcase
            end
            ST_EXECUTE: begin
                case (class_r)
                    CL_OP: begin
                        alu_mode    = 2'd1;
                        state_nxt_s = ST_WB;
                    end
                    CL_OPIMM: begin
                        alu_b_sel   = 1'b1;
                        alu_mode    = 2'd1;
                        state_nxt_s = ST_WB;
                    end
                    CL_LUI: begin
                        alu_a_sel   = 2'd2;
                        alu_b_sel   = 1'b1;
                        state_nxt_s = ST_WB;
                    end
                    CL_AUIPC: begin
                        alu_a_sel   = 2'd1;
                        alu_b_sel   = 1'b1;
                        state_nxt_s = ST_WB;
                    end
                    CL_LOAD, CL_STORE: begin
                        alu_b_sel   = 1'b1;
                        state_nxt_s = ST_MEM;
                    end
                    CL_BRANCH: begin
                        alu_mode = 2'd2;
                        pc_src   = branch_taken ? 2'd1 : 2'd0;
                        retire_s = 1'b1;
                    end
                    CL_JAL, CL_JALR: begin
                        state_nxt_s = ST_WB;
                    end
                    default: begin
                        // Unreachable: only executable classes leave DECODE.
                        state_nxt_s      = ST_HALT;
                        halt_set_s       = 1'b1;
                        halt_cause_nxt_s = 2'd2;
                    end
                endcase
            end
            ST_MEM: begin
                mem.mem_req      = 1'b1;
                mem.mem_addr_sel = 1'b1;
                mem.mem_we       = (class_r == CL_STORE);
                wd_inc_s         = !mem.mem_ready;
                timeout_s        = WD_EN && !mem.mem_ready && (wd_cnt_r == WD_LAST);
                if (mem.mem_ready) begin
                    if (class_r == CL_STORE) begin
                        retire_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_WB;
                    end
                end else if (timeout_s) begin
                    state_nxt_s      = ST_HALT;
                    halt_set_s       = 1'b1;
                    halt_cause_nxt_s = 2'd3;
                end else begin
                    state_nxt_s = ST_MEM;
                end
            end
            ST_WB: begin
                reg_we   = 1'b1;
                retire_s = 1'b1;
                case (class_r)
                    CL_LOAD: wb_sel = 2'd1;
                    CL_JAL: begin
                        wb_sel = 2'd2;
                        pc_src = 2'd1;
                    end
                    CL_JALR: begin
                        wb_sel = 2'd2;
                        pc_src = 2'd2;
                    end
                    default: wb_sel = 2'd0;
                endcase
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // Retirement is the only instruction boundary where run is honoured.
        if (retire_s) begin
            pc_we       = 1'b1;
            state_nxt_s = run ? ST_FETCH : ST_IDLE;
        end else begin
            pc_we = 1'b0;
        end

        wd_clr_s = (state_nxt_s != state_r) &&
                   ((state_nxt_s == ST_FETCH) || (state_nxt_s == ST_MEM));
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Instruction class captured once in DECODE for the later states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            class_r <= CL_OP;
        end else if (state_r == ST_DECODE) begin
            class_r <= op_class_s;
        end
    end

    // Memory-wait watchdog: restarts on each new request, counts idle cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_r <= '0;
        end else if (wd_clr_s) begin
            wd_cnt_r <= '0;
        end else if (wd_inc_s) begin
            wd_cnt_r <= wd_cnt_r + CW'(1);
        end
    end

    // Halt reason, sticky until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halt_cause_r <= 2'd0;
        end else if (halt_set_s) begin
            halt_cause_r <= halt_cause_nxt_s;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret_r <= 32'd0;
        end else if (retire_s) begin
            instret_r <= instret_r + 32'd1;
        end
    end

    assign state      = state_r;
    assign halted     = (state_r == ST_HALT);
    assign halt_cause = halt_cause_r;
    assign instret    = instret_r;

endmodule
